// File: rtl/spi_crc_pkg.sv
// spi_crc_pkg: shared sizing helpers and receiver FSM state type
package spi_crc_pkg;

    localparam int WCODE_DEFAULT = 3;
    localparam int WPOLY_DEFAULT = 4;
    localparam int FLEN          = WCODE_DEFAULT + WPOLY_DEFAULT - 1;
    localparam int ARGB_W        = 2 * WPOLY_DEFAULT - 1;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WAIT_CS
    } rx_state_t;

    function automatic int frame_len(input int wcode, input int wpoly);
        return wcode + wpoly - 1;
    endfunction

    function automatic int argb_width(input int wpoly);
        return 2 * wpoly - 1;
    endfunction

endpackage

// File: rtl/spi_crc_frame_rx_sync.sv
// spi_in_sync: multi-flop synchroniser with history flop and registered edge detect
module spi_in_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES:0]   fill_q, fill_d;
    logic                   hist_q, hist_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
        hist_d = sync_q[SYNC_STAGES-1];
        fill_d = {fill_q[SYNC_STAGES-1:0], 1'b1};
        // Edges count only once hist holds a real sample, so a level already present at reset is not an edge
        rise_d = fill_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~hist_q;
        fall_d = fill_q[SYNC_STAGES] & ~sync_q[SYNC_STAGES-1] & hist_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
            fill_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_level = hist_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/spi_crc_frame_rx.sv
// spi_crc_frame_rx: SPI slave frame deserialiser feeding a single-entry valid/ready buffer
module spi_crc_frame_rx
    import spi_crc_pkg::*;
#(
    parameter int WCODE       = WCODE_DEFAULT,
    parameter int WPOLY       = WPOLY_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sck,
    input  logic               i_cs_n,
    input  logic               i_mosi,
    input  logic [WPOLY-1:0]   i_poly,
    output logic [WCODE-1:0]   o_data,
    output logic [2*WPOLY-2:0] o_argB,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_frame_err,
    output logic               o_overrun,
    output logic               o_busy
);

    localparam int FL = frame_len(WCODE, WPOLY);
    localparam int AW = argb_width(WPOLY);
    localparam int CW = $clog2(FL + 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_sck),
        .o_level(sck_lvl), .o_rise(sck_rise), .o_fall(sck_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_cs_n),
        .o_level(cs_lvl), .o_rise(cs_rise), .o_fall(cs_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_mosi),
        .o_level(mosi), .o_rise(mosi_rise), .o_fall(mosi_fall)
    );

    assign unused_edges = ^{sck_lvl, sck_fall, cs_lvl, mosi_rise, mosi_fall};

    rx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [FL-1:0]    shift_q, shift_d, shifted;
    logic [WPOLY-1:0] poly_q, poly_d;
    logic [WCODE-1:0] data_q, data_d;
    logic [AW-1:0]    argb_q, argb_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             err_seen_q, err_seen_d;
    logic             load;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        poly_d     = poly_q;
        data_d     = data_q;
        argb_d     = argb_q;
        err_seen_d = err_seen_q;
        valid_d    = valid_q & ~i_ready;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        load       = 1'b0;
        shifted    = {shift_q[FL-2:0], mosi};
        cnt_inc    = cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    shift_d = '0;
                    poly_d  = i_poly;
                end
            end
            RECV: begin
                if (sck_rise) begin
                    shift_d = shifted;
                    cnt_d   = cnt_inc;
                end
                // A completing edge wins over a coincident CS rise: the count is already full
                if (sck_rise && cnt_inc == CW'(FL)) begin
                    load       = 1'b1;
                    err_seen_d = 1'b0;
                    state_d    = cs_rise ? IDLE : WAIT_CS;
                end else if (cs_rise) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_CS: begin
                if (sck_rise && !err_seen_q) begin
                    ferr_d     = 1'b1;
                    err_seen_d = 1'b1;
                end
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            if (!valid_q || i_ready) begin
                data_d  = shifted[FL-1:WPOLY-1];
                argb_d  = {poly_q, shifted[WPOLY-2:0]};
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            poly_q     <= '0;
            data_q     <= '0;
            argb_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            err_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            poly_q     <= poly_d;
            data_q     <= data_d;
            argb_q     <= argb_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            err_seen_q <= err_seen_d;
        end
    end

    assign o_data      = data_q;
    assign o_argB      = argb_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
    assign o_busy      = state_q != IDLE;

endmodule

// File: tb/tb_spi_crc_frame_rx.sv
// tb_spi_crc_frame_rx: directed SPI frames checked against a frame-level scoreboard model
module tb_spi_crc_frame_rx;
    import spi_crc_pkg::*;

    localparam int WC = WCODE_DEFAULT;
    localparam int WP = WPOLY_DEFAULT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              i_rst = 1'b1, sck = 1'b0, cs_n = 1'b1, mosi = 1'b0, i_ready = 1'b0;
    logic [WP-1:0]     i_poly = '0;
    logic [WC-1:0]     o_data;
    logic [ARGB_W-1:0] o_argB;
    logic              o_valid, o_frame_err, o_overrun, o_busy;

    spi_crc_frame_rx #(.WCODE(WC), .WPOLY(WP), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_sck(sck), .i_cs_n(cs_n), .i_mosi(mosi),
        .i_poly(i_poly), .o_data(o_data), .o_argB(o_argB), .o_valid(o_valid),
        .i_ready(i_ready), .o_frame_err(o_frame_err), .o_overrun(o_overrun), .o_busy(o_busy)
    );

    int vecs = 0, errs = 0;
    int ferr_seen = 0, ovr_seen = 0, exp_ferr = 0, exp_ovr = 0;
    logic [WC+ARGB_W-1:0] exp_q[$];
    bit run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame word received MSB first: data is the quotient by 2^(WP-1), crc the remainder
    task automatic expect_frame(input logic [FLEN-1:0] w, input logic [WP-1:0] poly);
        int v;
        logic [WC-1:0] d;
        logic [WP-2:0] c;
        v = int'(w);
        d = WC'(v / (1 << (WP - 1)));
        c = (WP-1)'(v % (1 << (WP - 1)));
        exp_q.push_back({d, poly, c});
    endtask

    task automatic spi_close();
        tick(3);
        cs_n = 1'b1;
        tick(5);
    endtask

    task automatic spi_frame(input logic [7:0] w, input int n, input logic [WP-1:0] pa,
                             input logic [WP-1:0] pb, input bit drain_last, input bit close);
        cs_n = 1'b0;
        i_poly = pa;
        tick(4);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = w[i];
            tick(2);
            sck = 1'b1;
            tick(3);
            if (drain_last && i == 0) begin
                i_ready = 1'b1;
                tick(1);
                i_ready = 1'b0;
            end
            sck = 1'b0;
            i_poly = pb;
        end
        if (close) spi_close();
    endtask

    task automatic settle(input string tag);
        chk({tag, "_ferr_count"}, ferr_seen, exp_ferr);
        chk({tag, "_ovr_count"}, ovr_seen, exp_ovr);
        chk({tag, "_frames_left"}, exp_q.size(), 0);
    endtask

    initial begin
        logic hold_p, ferr_p, ovr_p, pending;
        logic [WC+ARGB_W-1:0] out_p;
        hold_p = 1'b0;
        ferr_p = 1'b0;
        ovr_p  = 1'b0;
        out_p  = '0;
        forever begin
            @(negedge clk);
            if (run) begin
                if (hold_p) begin
                    chk("hold_valid", 32'(o_valid), 1);
                    chk("hold_data", 32'({o_data, o_argB}), 32'(out_p));
                end
                if (ferr_p) chk("ferr_width", 32'(o_frame_err), 0);
                if (ovr_p) chk("ovr_width", 32'(o_overrun), 0);
                if (o_valid && i_ready && !i_rst) begin
                    pending = exp_q.size() > 0;
                    chk("frame_avail", 32'(pending), 1);
                    if (pending) chk("frame", 32'({o_data, o_argB}), 32'(exp_q.pop_front()));
                end
                if (o_frame_err) ferr_seen++;
                if (o_overrun) ovr_seen++;
                hold_p = o_valid & ~i_ready & ~i_rst;
                out_p  = {o_data, o_argB};
                ferr_p = o_frame_err;
                ovr_p  = o_overrun;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_argb", 32'(o_argB), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_ferr", 32'(o_frame_err), 0);
        chk("rst_ovr", 32'(o_overrun), 0);
        tick(1);
        i_rst = 1'b0;
        run = 1'b1;
        tick(5);

        // good frame with 3-cycle latency from the last SCK sample
        i_ready = 1'b1;
        expect_frame(6'b101100, 4'b1011);
        spi_frame(8'b101100, 6, 4'b1011, 4'b1011, 1'b0, 1'b0);
        @(negedge clk);
        chk("good_busy", 32'(o_busy), 1);
        chk("good_lat_e2", 32'(o_valid), 0);
        tick(1);
        @(negedge clk);
        chk("good_lat_e3", 32'(o_valid), 1);
        chk("good_data", 32'(o_data), 32'(3'b101));
        chk("good_argb", 32'(o_argB), 32'(7'b1011100));
        tick(1);
        @(negedge clk);
        chk("good_drop", 32'(o_valid), 0);
        spi_close();
        @(negedge clk);
        chk("good_idle", 32'(o_busy), 0);
        tick(1);
        settle("good");

        // backpressure then overrun
        i_ready = 1'b0;
        expect_frame(6'b110001, 4'b1011);
        spi_frame(8'b110001, 6, 4'b1011, 4'b1011, 1'b0, 1'b1);
        spi_frame(8'b011010, 6, 4'b1011, 4'b1011, 1'b0, 1'b1);
        exp_ovr++;
        @(negedge clk);
        chk("ovr_valid", 32'(o_valid), 1);
        chk("ovr_data", 32'(o_data), 32'(3'b110));
        chk("ovr_argb", 32'(o_argB), 32'(7'b1011001));
        tick(1);
        i_ready = 1'b1;
        tick(2);
        @(negedge clk);
        chk("ovr_drained", 32'(o_valid), 0);
        tick(1);
        settle("ovr");

        // simultaneous drain and fill
        i_ready = 1'b0;
        expect_frame(6'b010111, 4'b1011);
        spi_frame(8'b010111, 6, 4'b1011, 4'b1011, 1'b0, 1'b1);
        expect_frame(6'b100110, 4'b1011);
        spi_frame(8'b100110, 6, 4'b1011, 4'b1011, 1'b1, 1'b1);
        @(negedge clk);
        chk("fill_valid", 32'(o_valid), 1);
        chk("fill_data", 32'(o_data), 32'(3'b100));
        tick(1);
        i_ready = 1'b1;
        tick(3);
        settle("fill");

        // short frame, then 7 and 8 edges in one CS window
        spi_frame(8'b1010, 4, 4'b1011, 4'b1011, 1'b0, 1'b1);
        exp_ferr++;
        settle("short");
        expect_frame(6'b110100, 4'b1011);
        spi_frame(8'b1101001, 7, 4'b1011, 4'b1011, 1'b0, 1'b1);
        exp_ferr++;
        expect_frame(6'b011101, 4'b1011);
        spi_frame(8'b01110110, 8, 4'b1011, 4'b1011, 1'b0, 1'b1);
        exp_ferr++;
        settle("long");

        // reset mid-frame with CS held low
        spi_frame(8'b101, 3, 4'b1011, 4'b1011, 1'b0, 1'b0);
        tick(1);
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        spi_frame(8'b100, 3, 4'b1011, 4'b1011, 1'b0, 1'b0);
        @(negedge clk);
        chk("midrst_busy", 32'(o_busy), 0);
        chk("midrst_valid", 32'(o_valid), 0);
        tick(1);
        spi_close();
        settle("midrst");
        expect_frame(6'b111000, 4'b1011);
        spi_frame(8'b111000, 6, 4'b1011, 4'b1011, 1'b0, 1'b1);
        settle("after_rst");

        // poly latched at frame start
        i_ready = 1'b0;
        expect_frame(6'b001011, 4'b1011);
        spi_frame(8'b001011, 6, 4'b1011, 4'b1101, 1'b0, 1'b1);
        @(negedge clk);
        chk("poly_first", 32'(o_argB[6:3]), 32'(4'b1011));
        tick(1);
        i_ready = 1'b1;
        tick(2);
        i_ready = 1'b0;
        expect_frame(6'b010101, 4'b1101);
        spi_frame(8'b010101, 6, 4'b1101, 4'b1101, 1'b0, 1'b1);
        @(negedge clk);
        chk("poly_next", 32'(o_argB[6:3]), 32'(4'b1101));
        tick(1);
        i_ready = 1'b1;
        tick(3);
        settle("poly");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/spi_crc_frame_rx.md
Name: spi_crc_frame_rx

Overview:
SPI slave-side frame deserialiser. It sits directly upstream of the SPI exe-unit CRC checker stage.
- Oversamples SCK/CS_n/MOSI in the system clock domain.
- Shifts in one frame of WCODE data bits followed by WPOLY-1 CRC bits, MSB first.
- Presents the frame as {data, argB={poly, crc}} on a single-entry valid/ready output buffer.
- Flags short frames, over-long frames and overruns.

Parameters:
WCODE, 3, data field width (bits)
WPOLY, 4, CRC divisor width (CRC field = WPOLY-1 bits)
SYNC_STAGES, 2, synchroniser depth on i_sck/i_cs_n/i_mosi (min 2)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_sck  in  1  SPI clock (async); data sampled on rising edge
i_cs_n  in  1  SPI chip select (async), active low, frames the transfer
i_mosi  in  1  SPI serial data (async)
i_poly  in  WPOLY  CRC divisor; latched at frame start
o_data  out  WCODE  received data field
o_argB  out  2*WPOLY-1  {latched poly, received crc}; 7 bits at defaults, consumed as-is by the checker
o_valid  out  1  output buffer holds a frame
i_ready  in  1  downstream accepts; transfer when o_valid & i_ready
o_frame_err  out  1  1-cycle pulse: short or over-long frame
o_overrun  out  1  1-cycle pulse: completed frame dropped because buffer was full
o_busy  out  1  FSM not in IDLE

Behaviour:
- FLEN = WCODE+WPOLY-1 (6 at defaults). Bit counter width is clog2(FLEN+1).
- Reset (i_rst=1 at an i_clk edge):
  - o_data=0, o_argB=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
  - FSM goes to IDLE; shift register, counter and synchroniser flops clear to 0, except cs_n flops, which clear to 1.
  - Reset mid-frame discards the partial frame.
- Input conditioning:
  - SYNC_STAGES-flop synchroniser per input, plus one history flop.
  - sck_rise = sync=1 & hist=0; cs_fall and cs_rise are derived the same way from cs_n.
  - MOSI uses the synchronised value aligned with sck_rise.
  - Requirement on the SPI side: SCK high and low phases each ≥2 i_clk periods.
- FSM states: IDLE, RECV, WAIT_CS.
  - IDLE:
    - On cs_fall: go to RECV; counter=0; latch i_poly.
    - Entry is edge-triggered, so CS already low after reset is ignored until CS goes high then low again.
  - RECV:
    - Each sck_rise: shift_reg <= {shift_reg[FLEN-2:0], mosi}; counter+1.
    - If that sck_rise makes counter==FLEN: attempt output load in the same cycle, then go to WAIT_CS.
    - cs_rise with counter<FLEN: o_frame_err pulse, frame discarded, go to IDLE.
    - If sck_rise and cs_rise coincide, the edge is shifted first, then the CS rule is applied to the updated count.
  - WAIT_CS:
    - Any sck_rise: o_frame_err pulse (once per frame); output already loaded is not retracted.
    - cs_rise: go to IDLE.
- Output load:
  - o_data = shifted[FLEN-1:WPOLY-1]; o_argB = {poly_latched, shifted[WPOLY-2:0]}.
  - Load allowed when o_valid=0, or when o_valid & i_ready in the same cycle (simultaneous drain and fill → o_valid stays 1 with the new frame).
  - Otherwise: o_overrun pulse; buffer keeps the old frame unchanged.
- Handshake:
  - o_valid stays high until o_valid & i_ready.
  - o_data/o_argB are stable while o_valid & ~i_ready.
  - o_valid falls the cycle after acceptance unless refilled.
- Latency (SYNC_STAGES=2): i_clk edge E0 first samples i_sck=1 for the last bit → o_valid=1 after edge E3.
- Pulses o_frame_err and o_overrun are registered, exactly 1 cycle each.

Decomposition:
- Package spi_crc_pkg:
  - WCODE/WPOLY defaults
  - FLEN and ARGB_W localparams as functions of WCODE/WPOLY
  - rx_state_t enum {IDLE, RECV, WAIT_CS}
- One sub-module, spi_in_sync: SYNC_STAGES-flop synchroniser plus history flop. Outputs level, rise and fall. Instantiated three times.

Test Plan:
- Good frame: i_poly=4'b1011; CS low; bits 1,0,1,1,0,0; CS high; i_ready=1 → o_valid for 1 cycle, o_data=3'b101, o_argB=7'b1011100, 3-cycle latency from last SCK sample; the checker fed with this frame outputs 3'b000.
- Backpressure and overrun: i_ready=0; send 3'b110+3'b001, then 3'b011+3'b010 → first frame held stable (o_data=3'b110, o_argB=7'b1011001), o_overrun one pulse at second completion; raise i_ready → o_valid drops.
- Simultaneous drain and fill: i_ready asserted in the exact cycle the second frame completes → no o_overrun, o_valid stays 1, o_data switches to the second frame.
- Short and long frames: CS high after 4 bits → o_frame_err pulse, o_valid stays 0. 7 SCK edges in one CS window → frame loaded from the first 6 bits plus one o_frame_err pulse.
- Reset mid-frame: i_rst for 1 cycle after 3 bits with CS still low, remaining bits sent → no o_valid, no error, o_busy=0 until next CS fall; the next full frame is received correctly.
- Poly latch: i_poly changed from 4'b1011 to 4'b1101 mid-frame → o_argB[6:3]=4'b1011 for that frame, 4'b1101 for the next.
